// File: rtl/irq_seq.sv
// Interrupt entry/return sequencer: waits for a takeable commit point, redirects to the handler,
// and redirects back to the saved PC on ERET. Optional post-ERET hold-off via IRQ_SEQ_HOLDOFF_EN.
module irq_seq #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_0380,
   parameter int          HOLDOFF    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        timer_irq,
   input  logic        io_irq,
   input  logic        soft_irq,
   input  logic        pc_valid,
   input  logic [31:0] pc_in,
   input  logic        in_delay_slot,
   input  logic        eret,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc_out,
   output logic        bd,
   output logic        exl,
   output logic [2:0]  irq_src,
   output logic        busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_ENTER   = 3'd2;
   localparam logic [2:0] S_HANDLER = 3'd3;
   localparam logic [2:0] S_RETURN  = 3'd4;
`ifdef IRQ_SEQ_HOLDOFF_EN
   localparam logic [2:0] S_HOLDOFF = 3'd5;
   localparam int         HOLD_W    = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
   // A HOLDOFF of 0 or 1 still spends one cycle in the hold-off state.
   localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLDOFF > 1) ? HOLD_W'(HOLDOFF - 1) : '0;

   logic [HOLD_W-1:0] cnt_q, cnt_d;
`endif

   logic [2:0]  state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic        bd_q, bd_d;
   logic [2:0]  src_q, src_d;
   logic        any_irq;

   assign any_irq = timer_irq | io_irq | soft_irq;

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      bd_d    = bd_q;
      src_d   = src_q;
`ifdef IRQ_SEQ_HOLDOFF_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (any_irq) begin
               state_d = S_WAIT;
               src_d   = timer_irq ? 3'b100 : (io_irq ? 3'b010 : 3'b001);
            end
         end
         S_WAIT: begin
            if (pc_valid) begin
               // A delay-slot instruction resumes at its branch, one word earlier.
               epc_d   = in_delay_slot ? (pc_in - 32'd4) : pc_in;
               bd_d    = in_delay_slot;
               state_d = S_ENTER;
            end else if (!any_irq) begin
               state_d = S_IDLE;
            end
         end
         S_ENTER:   state_d = S_HANDLER;
         S_HANDLER: begin
            if (eret && pc_valid) begin
               state_d = S_RETURN;
            end
         end
`ifdef IRQ_SEQ_HOLDOFF_EN
         S_RETURN: begin
            state_d = S_HOLDOFF;
            cnt_d   = '0;
         end
         S_HOLDOFF: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`else
         S_RETURN:  state_d = S_IDLE;
`endif
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         epc_q   <= '0;
         bd_q    <= 1'b0;
         src_q   <= 3'b000;
`ifdef IRQ_SEQ_HOLDOFF_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         bd_q    <= bd_d;
         src_q   <= src_d;
`ifdef IRQ_SEQ_HOLDOFF_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign flush       = (state_q == S_ENTER) || (state_q == S_RETURN);
   assign redirect    = flush;
   assign redirect_pc = (state_q == S_ENTER)  ? HANDLER_PC :
                        (state_q == S_RETURN) ? epc_q : 32'd0;
   assign exl         = (state_q == S_ENTER) || (state_q == S_HANDLER);
   assign busy        = (state_q != S_IDLE);
   assign epc_out     = epc_q;
   assign bd          = bd_q;
   assign irq_src     = src_q;

endmodule

// File: doc/irq_seq.md
IRQ_SEQ -- requirements
Module: irq_seq

Interface
REQ-001 SHALL have parameter HANDLER_PC, default 32'h0000_0380: handler entry address driven on redirect_pc when entering the handler.
REQ-002 SHALL have parameter HOLDOFF, default 4: post-ERET hold-off length in cycles, used only when the Configuration macro is defined.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have ports timer_irq, io_irq, soft_irq  in  1 each: gated interrupt requests from the interrupt request block.
REQ-006 SHALL have port pc_valid  in  1: the instruction at the commit point is valid and may be taken.
REQ-007 SHALL have port pc_in  in  32: PC of the instruction at the commit point.
REQ-008 SHALL have port in_delay_slot  in  1: the commit-point instruction is in a branch delay slot.
REQ-009 SHALL have port eret  in  1: ERET is at the commit point.
REQ-010 SHALL have ports flush and redirect  out  1 each: squash the pipeline and load redirect_pc.
REQ-011 SHALL have port redirect_pc  out  32: fetch target while redirect=1; 0 otherwise.
REQ-012 SHALL have ports epc_out  out  32, bd  out  1, and exl  out  1: saved return PC, branch-delay flag, and exception level.
REQ-013 SHALL have port irq_src  out  3: {timer,io,soft}, a one-hot latch of the source taken.
REQ-014 SHALL have port busy  out  1: state is not IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT, ENTER, HANDLER, RETURN, and HOLDOFF (HOLDOFF only with the macro); all outputs are registered or decoded from state.
REQ-016 In IDLE, any irq=1 SHALL move to WAIT next cycle and latch irq_src with priority timer > io > soft.
REQ-017 In WAIT with pc_valid=1, SHALL capture epc_out = in_delay_slot ? pc_in-4 (mod 2^32) : pc_in, capture bd = in_delay_slot, and move to ENTER.
REQ-018 In WAIT with pc_valid=0 and all irq=0, SHALL return to IDLE with no capture; irq_src holds its value.
REQ-019 ENTER SHALL last exactly 1 cycle with flush=1, redirect=1, redirect_pc=HANDLER_PC, then move to HANDLER.
REQ-020 exl SHALL be 1 in ENTER and HANDLER and 0 in all other states.
REQ-021 In HANDLER, irq inputs SHALL be ignored; eret=1 with pc_valid=1 SHALL move to RETURN.
REQ-022 eret SHALL be ignored in every state other than HANDLER.
REQ-023 RETURN SHALL last exactly 1 cycle with flush=1, redirect=1, redirect_pc=epc_out, then move to IDLE (or HOLDOFF with the macro).
REQ-024 flush and redirect SHALL be 0 in every state except ENTER and RETURN.
REQ-025 Latency: irq rising at cycle N with pc_valid=1 SHALL give flush=1 at cycle N+2.
REQ-026 epc_out, bd and irq_src SHALL change only on a WAIT capture (irq_src: on an IDLE->WAIT transition) and SHALL hold otherwise.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, epc_out=0, bd=0, irq_src=3'b000, hold-off counter=0, and hence flush=redirect=exl=busy=0 and redirect_pc=0.
REQ-028 rst in any state, including HANDLER, SHALL abandon the sequence with no RETURN redirect.

Configuration
REQ-029 Macro IRQ_SEQ_HOLDOFF_EN defined: RETURN SHALL move to HOLDOFF, which counts HOLDOFF cycles with irqs ignored, busy=1 and exl=0, then moves to IDLE.
REQ-030 Macro IRQ_SEQ_HOLDOFF_EN undefined: the HOLDOFF state and counter SHALL be absent, and RETURN SHALL move directly to IDLE.

Verification
REQ-031 Entry scenario: io_irq=1 at cycle 0, pc_valid=1, pc_in=32'h0000_1000, in_delay_slot=0 -> cycle 2 flush=redirect=1, redirect_pc=32'h0000_0380, epc_out=32'h0000_1000, irq_src=3'b010; cycle 3 exl=1.
REQ-032 Delay-slot scenario: pc_in=32'h0000_2004, in_delay_slot=1 during WAIT -> epc_out=32'h0000_2000, bd=1.
REQ-033 Priority and return scenario: timer_irq=soft_irq=1 together -> irq_src=3'b100; in HANDLER, eret=1 with pc_valid=1 -> next cycle redirect_pc=epc_out, then exl=0 and IDLE.
REQ-034 Cancel scenario: irq pulse of 1 cycle with pc_valid=0 for 3 cycles -> WAIT then IDLE, no flush, epc_out unchanged.
REQ-035 Reset scenario: rst=1 during HANDLER -> next cycle all outputs 0 and busy=0; irq_src=3'b000.
REQ-036 Hold-off scenario (macro defined): io_irq=1 held through RETURN -> no new WAIT for 4 cycles, then re-entry.
